// File: rtl/seq_multiplier_if.sv
// ---------------------------------------------------------------------------
// seq_multiplier_if
//   Request/response bundle between an issuing stage and seq_multiplier.
//
//   Handshake: start is a request that is taken at a rising clk edge only
//   while the multiplier can accept it, which is whenever busy is low
//   (IDLE or the one-cycle DONE state). A request raised while busy is
//   high is ignored and must be re-presented by the master. done is a
//   one-cycle pulse that marks result_hi/result_lo as the product of the
//   most recently accepted request. The results then hold until the next
//   completion.
//
//   Signals
//     start      master -> slave  request a multiply
//     is_signed  master -> slave  1 = two's-complement operands
//     op_a       master -> slave  multiplicand
//     op_b       master -> slave  multiplier
//     busy       slave  -> master operation iterating
//     done       slave  -> master one-cycle product-valid pulse
//     result_hi  slave  -> master upper half of the product
//     result_lo  slave  -> master lower half of the product
//     state      slave  -> master FSM state, for observation only
// ---------------------------------------------------------------------------
interface seq_multiplier_if #(
  parameter int DWIDTH = 32
);
  logic              start;
  logic              is_signed;
  logic [DWIDTH-1:0] op_a;
  logic [DWIDTH-1:0] op_b;
  logic              busy;
  logic              done;
  logic [DWIDTH-1:0] result_hi;
  logic [DWIDTH-1:0] result_lo;
  logic [1:0]        state;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, result_hi, result_lo, state
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, result_hi, result_lo, state
  );
endinterface

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-and-add multiplier, one partial product per cycle,
//   DWIDTH cycles per operation. Signed operands are handled by multiplying
//   magnitudes and negating the full-width product at completion.
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    seq_multiplier_if slave modport (start/operands in,
//            busy/done/results/state out); its DWIDTH must match ours
//
//   Parameters
//     DWIDTH  operand width, product is 2*DWIDTH bits
//     CWIDTH  iteration counter width, 2**CWIDTH > DWIDTH
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_multiplier_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CWIDTH-1:0]   cnt_q;
  logic [2*DWIDTH-1:0] mcand_q;
  logic [DWIDTH-1:0]   mplier_q;
  logic [2*DWIDTH-1:0] acc_q;
  logic                neg_q;
  logic [DWIDTH-1:0]   res_hi_q;
  logic [DWIDTH-1:0]   res_lo_q;

  logic                accept;
  logic                last_iter;
  logic [DWIDTH-1:0]   abs_a;
  logic [DWIDTH-1:0]   abs_b;
  logic [2*DWIDTH-1:0] acc_add;
  logic [2*DWIDTH-1:0] product;
  logic                busy_c;
  logic                done_c;

  // Requests are taken in IDLE and in DONE, so back-to-back operations
  // need no gap cycle.
  assign accept    = bus.start && (state_q == IDLE || state_q == DONE);
  // The counter reaches DWIDTH on the edge that performs this iteration.
  assign last_iter = (cnt_q == CWIDTH'(DWIDTH - 1));

  // Magnitudes fit in DWIDTH unsigned bits, including 2**(DWIDTH-1).
  assign abs_a = (bus.is_signed && bus.op_a[DWIDTH-1]) ? -bus.op_a : bus.op_a;
  assign abs_b = (bus.is_signed && bus.op_b[DWIDTH-1]) ? -bus.op_b : bus.op_b;

  assign acc_add = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product = neg_q ? -acc_add : acc_add;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      RUN:     busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, iteration, and result load at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      mcand_q  <= {{DWIDTH{1'b0}}, abs_a};
      mplier_q <= abs_b;
      acc_q    <= '0;
      neg_q    <= bus.is_signed & (bus.op_a[DWIDTH-1] ^ bus.op_b[DWIDTH-1]);
    end else if (state_q == RUN) begin
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_add;
      if (last_iter) begin
        res_hi_q <= product[2*DWIDTH-1:DWIDTH];
        res_lo_q <= product[DWIDTH-1:0];
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.result_hi = res_hi_q;
  assign bus.result_lo = res_lo_q;
  assign bus.state     = state_q;

endmodule
